tlb_lookup_ctrl: RTL

TLB_LOOKUP_CTRL -- requirements
Module: tlb_lookup_ctrl

---
 rtl/tlb_pkg.sv | 15 +
 rtl/tlb_match.sv | 28 ++
 rtl/tlb_lookup_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared widths, TLB geometry and FSM encoding for the TLB lookup controller
package tlb_pkg;
   localparam int VPN_W       = 20;
   localparam int PPN_W       = 22;
   localparam int FLAG_W      = 8;
   localparam int TLB_ENTRIES = 32;
   localparam int TLB_IDX_W   = 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_WALK   = 2'd2,
      ST_RESP   = 2'd3
   } tlb_state_e;
endpackage

// File: rtl/tlb_match.sv
// rtl/tlb_match.sv - N-way key comparator with lowest-index priority encoder
module tlb_match #(
   parameter int N     = 32,
   parameter int IDX_W = 5,
   parameter int KEY_W = 20
) (
   input  logic [N-1:0]       en,
   input  logic [N*KEY_W-1:0] keys,
   input  logic [KEY_W-1:0]   key,
   output logic               hit,
   output logic [IDX_W-1:0]   idx
);
   logic [N-1:0] match;

   // Scan from the top down so the lowest matching index is the last one written.
   always_comb begin
      hit   = 1'b0;
      idx   = '0;
      match = '0;
      for (int i = N - 1; i >= 0; i--) begin
         match[i] = en[i] && (keys[i*KEY_W +: KEY_W] == key);
         if (match[i]) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end
endmodule

// File: rtl/tlb_lookup_ctrl.sv
// rtl/tlb_lookup_ctrl.sv - fully associative TLB with single outstanding page-table walk and PLRU hooks
module tlb_lookup_ctrl import tlb_pkg::*; #(
   parameter int VPN_W   = tlb_pkg::VPN_W,
   parameter int PPN_W   = tlb_pkg::PPN_W,
   parameter int FLAG_W  = tlb_pkg::FLAG_W,
   parameter int ENTRIES = TLB_ENTRIES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   input  logic [VPN_W-1:0]     req_vpn,
   output logic                 req_ready,
   output logic                 resp_valid,
   output logic                 resp_hit,
   output logic                 resp_fault,
   output logic [PPN_W-1:0]     resp_ppn,
   output logic [FLAG_W-1:0]    resp_flags,
   output logic                 ptw_req_valid,
   output logic [VPN_W-1:0]     ptw_req_vpn,
   input  logic                 ptw_resp_valid,
   input  logic [PPN_W-1:0]     ptw_resp_ppn,
   input  logic [FLAG_W-1:0]    ptw_resp_flags,
   input  logic                 ptw_resp_fault,
   input  logic                 flush,
   output logic                 lru_access,
   output logic [TLB_IDX_W-1:0] lru_addr_access,
   output logic                 lru_compare,
   input  logic [TLB_IDX_W-1:0] lru_victim
);
   tlb_state_e state_q, state_d;

   logic [VPN_W-1:0]          vpn_q, vpn_d;
   logic                      drop_q, drop_d;
   logic [ENTRIES-1:0]        valid_q, valid_d;
   logic [ENTRIES*VPN_W-1:0]  tag_q, tag_d;
   logic [ENTRIES*PPN_W-1:0]  ppn_q, ppn_d;
   logic [ENTRIES*FLAG_W-1:0] flags_q, flags_d;

   logic                      resp_hit_q, resp_hit_d;
   logic                      resp_fault_q, resp_fault_d;
   logic [PPN_W-1:0]          resp_ppn_q, resp_ppn_d;
   logic [FLAG_W-1:0]         resp_flags_q, resp_flags_d;

   logic                      hit_any;
   logic [TLB_IDX_W-1:0]      hit_idx;
   logic                      inv_any;
   logic [TLB_IDX_W-1:0]      inv_idx;
   logic [TLB_IDX_W-1:0]      victim;
   logic                      lookup_hit;
   logic                      walk_done;
   logic                      refill;

   tlb_match #(
      .N     (ENTRIES),
      .IDX_W (TLB_IDX_W),
      .KEY_W (VPN_W)
   ) u_hit_match (
      .en   (valid_q),
      .keys (tag_q),
      .key  (vpn_q),
      .hit  (hit_any),
      .idx  (hit_idx)
   );

   // Same encoder with a constant key finds the lowest free slot.
   tlb_match #(
      .N     (ENTRIES),
      .IDX_W (TLB_IDX_W),
      .KEY_W (1)
   ) u_free_match (
      .en   (~valid_q),
      .keys ({ENTRIES{1'b0}}),
      .key  (1'b0),
      .hit  (inv_any),
      .idx  (inv_idx)
   );

   // A flush in the lookup cycle forces a miss; a flush or a pending drop blocks the refill.
   assign lookup_hit = (state_q == ST_LOOKUP) && hit_any && !flush;
   assign walk_done  = (state_q == ST_WALK) && ptw_resp_valid;
   assign refill     = walk_done && !ptw_resp_fault && !drop_q && !flush;
   assign victim     = inv_any ? inv_idx : lru_victim;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         vpn_q        <= '0;
         drop_q       <= 1'b0;
         valid_q      <= '0;
         resp_hit_q   <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_ppn_q   <= '0;
         resp_flags_q <= '0;
      end else begin
         state_q      <= state_d;
         vpn_q        <= vpn_d;
         drop_q       <= drop_d;
         valid_q      <= valid_d;
         resp_hit_q   <= resp_hit_d;
         resp_fault_q <= resp_fault_d;
         resp_ppn_q   <= resp_ppn_d;
         resp_flags_q <= resp_flags_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q   <= tag_d;
      ppn_q   <= ppn_d;
      flags_q <= flags_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (req_valid) state_d = ST_LOOKUP;
         ST_LOOKUP: state_d = lookup_hit ? ST_RESP : ST_WALK;
         ST_WALK:   if (ptw_resp_valid) state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      vpn_d        = vpn_q;
      valid_d      = valid_q;
      tag_d        = tag_q;
      ppn_d        = ppn_q;
      flags_d      = flags_q;
      resp_hit_d   = resp_hit_q;
      resp_fault_d = resp_fault_q;
      resp_ppn_d   = resp_ppn_q;
      resp_flags_d = resp_flags_q;

      if ((state_q == ST_IDLE) && req_valid) begin
         vpn_d = req_vpn;
      end

      drop_d = (state_q == ST_WALK) && !ptw_resp_valid && (drop_q || flush);

      if (refill) begin
         valid_d[victim]                     = 1'b1;
         tag_d[victim*VPN_W +: VPN_W]        = vpn_q;
         ppn_d[victim*PPN_W +: PPN_W]        = ptw_resp_ppn;
         flags_d[victim*FLAG_W +: FLAG_W]    = ptw_resp_flags;
      end

      if (flush) begin
         valid_d = '0;
      end

      if (lookup_hit) begin
         resp_hit_d   = 1'b1;
         resp_fault_d = 1'b0;
         resp_ppn_d   = ppn_q[hit_idx*PPN_W +: PPN_W];
         resp_flags_d = flags_q[hit_idx*FLAG_W +: FLAG_W];
      end else if (walk_done) begin
         resp_hit_d   = 1'b0;
         resp_fault_d = ptw_resp_fault;
         resp_ppn_d   = ptw_resp_fault ? '0 : ptw_resp_ppn;
         resp_flags_d = ptw_resp_fault ? '0 : ptw_resp_flags;
      end
   end

   // Every output is forced low while reset is held, whatever state the flops still hold.
   always_comb begin
      req_ready       = rst_n && (state_q == ST_IDLE);
      resp_valid      = rst_n && (state_q == ST_RESP);
      resp_hit        = rst_n && resp_hit_q;
      resp_fault      = rst_n && resp_fault_q;
      resp_ppn        = rst_n ? resp_ppn_q : '0;
      resp_flags      = rst_n ? resp_flags_q : '0;
      ptw_req_valid   = rst_n && (state_q == ST_WALK);
      ptw_req_vpn     = (rst_n && (state_q == ST_WALK)) ? vpn_q : '0;
      lru_compare     = rst_n && (state_q == ST_WALK);
      lru_access      = rst_n && (lookup_hit || refill);
      lru_addr_access = '0;
      if (rst_n && lookup_hit) begin
         lru_addr_access = hit_idx;
      end else if (rst_n && refill) begin
         lru_addr_access = victim;
      end
   end
endmodule
